// File: rtl/reg_bank_32_pkg.sv
// Shared constants for the 32-entry register bank: register indices and
// default reset values.
package reg_bank_32_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ZERO_IDX = 0;
  localparam int unsigned GP_IDX   = 28;
  localparam int unsigned SP_IDX   = 29;

  localparam logic [31:0] SP_RESET_VAL = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_RESET_VAL = 32'h1000_8000;

endpackage

// File: rtl/decoder_5to32.sv
// Write-enable decoder: raises exactly one bit of one_hot_o for the selected
// register when enabled, otherwise all bits are low.
module decoder_5to32 (
  input  logic        enable_i,
  input  logic [4:0]  sel_i,
  output logic [31:0] one_hot_o
);

  always_comb begin
    one_hot_o = '0;
    if (enable_i) begin
      one_hot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_en.sv
// Single WIDTH-bit register with load enable and asynchronous active-low reset
// to RST_VAL.
module reg_en #(
  parameter int unsigned       WIDTH   = 32,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_bank_32.sv
// Register-file storage: 31 writable registers plus a hardwired-zero r0, all
// presented in parallel to the downstream read multiplexers.
module reg_bank_32
  import reg_bank_32_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      SIZE     = 5,
  parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(SP_RESET_VAL),
  parameter logic [WIDTH-1:0] GP_RESET = WIDTH'(GP_RESET_VAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_write,
  input  logic [SIZE-1:0]  write_register,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] data_0,  data_1,  data_2,  data_3,
  output logic [WIDTH-1:0] data_4,  data_5,  data_6,  data_7,
  output logic [WIDTH-1:0] data_8,  data_9,  data_10, data_11,
  output logic [WIDTH-1:0] data_12, data_13, data_14, data_15,
  output logic [WIDTH-1:0] data_16, data_17, data_18, data_19,
  output logic [WIDTH-1:0] data_20, data_21, data_22, data_23,
  output logic [WIDTH-1:0] data_24, data_25, data_26, data_27,
  output logic [WIDTH-1:0] data_28, data_29, data_30, data_31
);

  logic [NUM_REGS-1:0] we;
  logic [WIDTH-1:0]    rd_data [NUM_REGS];
  logic                unused_we0;

  decoder_5to32 u_decoder (
    .enable_i  (reg_write),
    .sel_i     (write_register),
    .one_hot_o (we)
  );

  // r0 has no storage, so its decoded enable goes nowhere.
  assign unused_we0        = we[ZERO_IDX];
  assign rd_data[ZERO_IDX] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
    localparam logic [WIDTH-1:0] RstVal = (i == GP_IDX) ? GP_RESET :
                                          (i == SP_IDX) ? SP_RESET : '0;
    reg_en #(
      .WIDTH   (WIDTH),
      .RST_VAL (RstVal)
    ) u_reg (
      .clk_i  (clk),
      .rst_ni (reset),
      .en_i   (we[i]),
      .d_i    (write_data),
      .q_o    (rd_data[i])
    );
  end

  assign data_0  = rd_data[0];
  assign data_1  = rd_data[1];
  assign data_2  = rd_data[2];
  assign data_3  = rd_data[3];
  assign data_4  = rd_data[4];
  assign data_5  = rd_data[5];
  assign data_6  = rd_data[6];
  assign data_7  = rd_data[7];
  assign data_8  = rd_data[8];
  assign data_9  = rd_data[9];
  assign data_10 = rd_data[10];
  assign data_11 = rd_data[11];
  assign data_12 = rd_data[12];
  assign data_13 = rd_data[13];
  assign data_14 = rd_data[14];
  assign data_15 = rd_data[15];
  assign data_16 = rd_data[16];
  assign data_17 = rd_data[17];
  assign data_18 = rd_data[18];
  assign data_19 = rd_data[19];
  assign data_20 = rd_data[20];
  assign data_21 = rd_data[21];
  assign data_22 = rd_data[22];
  assign data_23 = rd_data[23];
  assign data_24 = rd_data[24];
  assign data_25 = rd_data[25];
  assign data_26 = rd_data[26];
  assign data_27 = rd_data[27];
  assign data_28 = rd_data[28];
  assign data_29 = rd_data[29];
  assign data_30 = rd_data[30];
  assign data_31 = rd_data[31];

endmodule

// File: tb/tb_reg_bank_32.sv
// Directed bench for reg_bank_32: stimulus pushes expected register contents
// into a queue, a monitor pops and compares them against the outputs.
module tb_reg_bank_32;

  logic        clk;
  logic        clk_en;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [31:0] d [32];

  typedef struct {
    string       name;
    int          idx;
    logic [31:0] exp;
  } chk_t;

  chk_t        chk_q[$];
  event        chk_ev;
  int          n_pass;
  int          n_total;
  logic [31:0] model [32];
  logic        done;

  reg_bank_32 dut (
    .clk            (clk),
    .reset          (reset),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .data_0  (d[0]),  .data_1  (d[1]),  .data_2  (d[2]),  .data_3  (d[3]),
    .data_4  (d[4]),  .data_5  (d[5]),  .data_6  (d[6]),  .data_7  (d[7]),
    .data_8  (d[8]),  .data_9  (d[9]),  .data_10 (d[10]), .data_11 (d[11]),
    .data_12 (d[12]), .data_13 (d[13]), .data_14 (d[14]), .data_15 (d[15]),
    .data_16 (d[16]), .data_17 (d[17]), .data_18 (d[18]), .data_19 (d[19]),
    .data_20 (d[20]), .data_21 (d[21]), .data_22 (d[22]), .data_23 (d[23]),
    .data_24 (d[24]), .data_25 (d[25]), .data_26 (d[26]), .data_27 (d[27]),
    .data_28 (d[28]), .data_29 (d[29]), .data_30 (d[30]), .data_31 (d[31])
  );

  // Gated clock so the reset test can run with the clock stopped.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Watchdog: the stimulus must complete within a bounded time.
  initial begin
    done = 1'b0;
    fork
      wait (done);
      #100000;
    join_any
    if (!done) begin
      $display("FAIL timeout: stimulus did not complete");
      $finish;
    end
  end

  // Monitor: compares every queued expectation when the stimulus samples.
  initial begin
    n_pass  = 0;
    n_total = 0;
    forever begin
      @(chk_ev);
      while (chk_q.size() > 0) begin
        chk_t c;
        c = chk_q.pop_front();
        n_total++;
        if (d[c.idx] === c.exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s: data_%0d got %h expected %h", c.name, c.idx, d[c.idx], c.exp);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[28] = 32'h1000_8000;
    model[29] = 32'h7FFF_EFFC;
  endtask

  task automatic push_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      chk_t c;
      c.name = $sformatf("%s_d%0d", tag, i);
      c.idx  = i;
      c.exp  = model[i];
      chk_q.push_back(c);
    end
  endtask

  task automatic flush();
    ->chk_ev;
    #1;
  endtask

  // Called just after a falling edge; checks old values in the write cycle,
  // then the updated values one cycle later.
  task automatic wr(input string tag, input logic en, input int idx, input logic [31:0] val);
    reg_write      = en;
    write_register = idx[4:0];
    write_data     = val;
    push_all({tag, "_pre"});
    flush();
    @(posedge clk);
    @(negedge clk);
    if (en && idx != 0) model[idx] = val;
    push_all({tag, "_post"});
    flush();
  endtask

  initial begin
    clk_en         = 1'b0;
    reset          = 1'b1;
    reg_write      = 1'b0;
    write_register = '0;
    write_data     = '0;

    // 1: asynchronous reset with no clock running
    #3 reset = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      n_total++;
      if (d[i] !== model[i]) begin
        $display("FAIL rst_direct: data_%0d got %h expected %h", i, d[i], model[i]);
      end else begin
        n_pass++;
      end
    end
    push_all("rst");
    flush();
    reg_write = 1'b1;
    write_register = 5'd29;
    write_data = 32'hFFFF_FFFF;
    #1 reset = 1'b1;
    reg_write = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);

    // 2: basic write with one-cycle latency
    wr("w5", 1'b1, 5, 32'hDEAD_BEEF);

    // 3: r0 ignores writes; reg_write=0 changes nothing
    wr("w0", 1'b1, 0, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) wr("nowe", 1'b0, 7, 32'h1234_5678);

    // 4: fill every register
    for (int k = 1; k < 32; k++) wr($sformatf("fill%0d", k), 1'b1, k, 32'(k) * 32'h0101_0101);

    // 5: reset pulse covering a write edge
    wr("w29", 1'b1, 29, 32'hAAAA_5555);
    reg_write      = 1'b1;
    write_register = 5'd3;
    write_data     = 32'h1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    push_all("rstpulse");
    flush();
    #3 reset = 1'b1;
    @(negedge clk);
    reg_write = 1'b0;
    push_all("postrst");
    flush();

    // 6: back-to-back writes to the same register
    wr("b2b1", 1'b1, 31, 32'h1);
    wr("b2b2", 1'b1, 31, 32'h2);
    wr("b2b3", 1'b1, 31, 32'h3);

    #1;
    done = 1'b1;
    if (n_total == 0 || n_pass != n_total) begin
      $display("FAIL: %0d/%0d checks passed", n_pass, n_total);
    end else begin
      $display("PASS: %0d/%0d checks passed", n_pass, n_total);
    end
    $finish;
  end

endmodule
